id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 92 +++++++++
 tb/tb_id_ex_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode-to-execute buffer: a two-entry head/skid register pair with decode at push; pushed instruction visible one edge later.
// Backpressure: id_ready is the registered "skid empty" flag, so ex_ready never reaches id_ready combinationally.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_id_valid,
  input  logic [31:0] if_id_instr,
  input  logic [63:0] rA_data,
  input  logic [63:0] rB_data,
  output logic        id_ready,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ID_EX_valid,
  output logic [31:0] ID_EX_Instr,
  output logic [63:0] ID_EX_rA,
  output logic [63:0] ID_EX_rB,
  output logic [4:0]  ID_EX_rD,
  output logic [1:0]  ID_EX_ww,
  output logic        ID_EX_wb_en,
  output logic        ID_EX_illegal
);

  localparam logic [5:0] OPC_ALU = 6'b101010;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        wb_en;
    logic        illegal;
  } entry_t;

  entry_t head_q, skid_q, in_ent;
  logic   head_vld, skid_vld;
  logic   push, pop, alu_op, nop;
  logic   head_load_in, head_load_skid, skid_load;

  always_comb begin
    nop            = (if_id_instr == 32'd0);
    alu_op         = (if_id_instr[31:26] == OPC_ALU) && (if_id_instr[5:0] != 6'd0);
    in_ent.instr   = if_id_instr;
    in_ent.ra      = rA_data;
    in_ent.rb      = rB_data;
    in_ent.illegal = ~nop & ~alu_op;
    in_ent.wb_en   = alu_op & (if_id_instr[25:21] != 5'd0);
  end

  // Skid full implies no push, so a popping head is refilled from skid or from the input, never both.
  always_comb begin
    push           = if_id_valid & ~skid_vld & ~flush;
    pop            = head_vld & ex_ready;
    head_load_skid = pop & skid_vld;
    head_load_in   = push & (~head_vld | (pop & ~skid_vld));
    skid_load      = push & head_vld & ~pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_vld <= 1'b0;
      skid_vld <= 1'b0;
      head_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      head_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      head_vld <= pop ? (skid_vld | push) : (head_vld | push);
      skid_vld <= skid_load | (skid_vld & ~pop);
      if (head_load_skid) begin
        head_q <= skid_q;
      end else if (head_load_in) begin
        head_q <= in_ent;
      end
      if (skid_load) begin
        skid_q <= in_ent;
      end
    end
  end

  always_comb begin
    id_ready      = ~skid_vld;
    ID_EX_valid   = head_vld;
    ID_EX_Instr   = head_q.instr;
    ID_EX_rA      = head_q.ra;
    ID_EX_rB      = head_q.rb;
    ID_EX_rD      = head_q.instr[25:21];
    ID_EX_ww      = head_q.instr[7:6];
    ID_EX_wb_en   = head_vld & head_q.wb_en;
    ID_EX_illegal = head_vld & head_q.illegal;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: queue-based reference model checked every cycle, plus hand-computed literal checks.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [63:0] rA_data, rB_data;
  logic        id_ready, flush, ex_ready;
  logic        ID_EX_valid;
  logic [31:0] ID_EX_Instr;
  logic [63:0] ID_EX_rA, ID_EX_rB;
  logic [4:0]  ID_EX_rD;
  logic [1:0]  ID_EX_ww;
  logic        ID_EX_wb_en, ID_EX_illegal;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .rA_data(rA_data), .rB_data(rB_data), .id_ready(id_ready), .flush(flush),
    .ex_ready(ex_ready), .ID_EX_valid(ID_EX_valid), .ID_EX_Instr(ID_EX_Instr),
    .ID_EX_rA(ID_EX_rA), .ID_EX_rB(ID_EX_rB), .ID_EX_rD(ID_EX_rD), .ID_EX_ww(ID_EX_ww),
    .ID_EX_wb_en(ID_EX_wb_en), .ID_EX_illegal(ID_EX_illegal)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] VAND    = {6'b101010, 5'd3, 5'd1, 5'd2, 5'b00011, 6'b000001};
  localparam logic [31:0] ILL_OP  = {6'b111111, 5'd4, 5'd1, 5'd2, 5'b00001, 6'b000001};
  localparam logic [31:0] ILL_FN  = {6'b101010, 5'd4, 5'd1, 5'd2, 5'b00010, 6'b000000};
  localparam logic [31:0] VAND_R0 = {6'b101010, 5'd0, 5'd1, 5'd2, 5'b00000, 6'b000001};
  localparam logic [31:0] INS_A   = {6'b101010, 5'd5, 5'd1, 5'd2, 5'b00001, 6'b000101};
  localparam logic [31:0] INS_B   = {6'b101010, 5'd6, 5'd1, 5'd2, 5'b00010, 6'b000101};
  localparam logic [31:0] INS_C   = {6'b101010, 5'd7, 5'd1, 5'd2, 5'b00011, 6'b000101};

  typedef struct {
    logic [31:0] instr;
    logic [63:0] a;
    logic [63:0] b;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   run = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_legal_alu(input logic [31:0] i);
    return (i[31:26] == 6'b101010) && (i[5:0] != 6'd0);
  endfunction

  function automatic logic exp_illegal(input logic [31:0] i);
    return (i != 32'd0) && !exp_legal_alu(i);
  endfunction

  function automatic logic exp_wb(input logic [31:0] i);
    return exp_legal_alu(i) && (i[25:21] != 5'd0);
  endfunction

  // Reference model: an in-order queue of at most two instructions.
  always @(posedge clk or negedge rst) begin : model
    int   sz;
    ent_t e;
    if (!rst) begin
      q.delete();
    end else begin
      sz = q.size();
      if (flush) begin
        q.delete();
      end else begin
        if (sz > 0 && ex_ready) void'(q.pop_front());
        if (if_id_valid && sz < 2) begin
          e.instr = if_id_instr;
          e.a     = rA_data;
          e.b     = rB_data;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    ent_t h;
    if (run && rst === 1'b1) begin
      chk("id_ready", id_ready, q.size() < 2);
      chk("valid", ID_EX_valid, q.size() != 0);
      if (q.size() != 0) begin
        h = q[0];
        chk("instr", ID_EX_Instr, h.instr);
        chk("rA", ID_EX_rA, h.a);
        chk("rB", ID_EX_rB, h.b);
        chk("rD", ID_EX_rD, h.instr[25:21]);
        chk("ww", ID_EX_ww, h.instr[7:6]);
        chk("wb_en", ID_EX_wb_en, exp_wb(h.instr));
        chk("illegal", ID_EX_illegal, exp_illegal(h.instr));
      end else begin
        chk("wb_en_idle", ID_EX_wb_en, 1'b0);
        chk("illegal_idle", ID_EX_illegal, 1'b0);
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] ins, input logic [63:0] a,
                     input logic [63:0] b, input logic exr, input logic fl);
    if_id_valid = v;
    if_id_instr = ins;
    rA_data     = a;
    rB_data     = b;
    ex_ready    = exr;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, ID_EX_valid, 1'b0);
    chk({tag, "_instr"}, ID_EX_Instr, 32'd0);
    chk({tag, "_rA"}, ID_EX_rA, 64'd0);
    chk({tag, "_rB"}, ID_EX_rB, 64'd0);
    chk({tag, "_rD"}, ID_EX_rD, 5'd0);
    chk({tag, "_ww"}, ID_EX_ww, 2'd0);
    chk({tag, "_wb_en"}, ID_EX_wb_en, 1'b0);
    chk({tag, "_illegal"}, ID_EX_illegal, 1'b0);
    chk({tag, "_id_ready"}, id_ready, 1'b1);
  endtask

  logic [31:0] tbl [5];

  initial begin
    tbl = '{VAND, ILL_OP, ILL_FN, VAND_R0, 32'd0};
    rst = 1'b0;
    if_id_valid = 1'b0; if_id_instr = '0; rA_data = '0; rB_data = '0;
    ex_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b1;
    run = 1'b1;

    // Single VAND with one-edge latency
    cyc(1, VAND, 64'hFF00, 64'h0FF0, 1, 0);
    chk("vand_valid", ID_EX_valid, 1'b1);
    chk("vand_rD", ID_EX_rD, 5'd3);
    chk("vand_ww", ID_EX_ww, 2'b11);
    chk("vand_wb_en", ID_EX_wb_en, 1'b1);
    chk("vand_illegal", ID_EX_illegal, 1'b0);
    chk("vand_rA", ID_EX_rA, 64'hFF00);
    chk("vand_rB", ID_EX_rB, 64'h0FF0);

    // Decode corners, streamed back-to-back with simultaneous push/pop
    cyc(1, ILL_OP, 64'h1, 64'h2, 1, 0);
    chk("illop_illegal", ID_EX_illegal, 1'b1);
    chk("illop_wb_en", ID_EX_wb_en, 1'b0);
    cyc(1, ILL_FN, 64'h3, 64'h4, 1, 0);
    chk("illfn_illegal", ID_EX_illegal, 1'b1);
    cyc(1, VAND_R0, 64'h5, 64'h6, 1, 0);
    chk("rd0_wb_en", ID_EX_wb_en, 1'b0);
    chk("rd0_illegal", ID_EX_illegal, 1'b0);
    cyc(1, 32'd0, 64'h7, 64'h8, 1, 0);
    chk("nop_valid", ID_EX_valid, 1'b1);
    chk("nop_wb_en", ID_EX_wb_en, 1'b0);
    chk("nop_illegal", ID_EX_illegal, 1'b0);
    cyc(0, 32'd0, 64'h0, 64'h0, 1, 0);
    chk("drain_valid", ID_EX_valid, 1'b0);

    // Backpressure: third instruction held upstream, then in-order drain
    cyc(1, INS_A, 64'hA, 64'hA0, 0, 0);
    cyc(1, INS_B, 64'hB, 64'hB0, 0, 0);
    chk("bp_ready_full", id_ready, 1'b0);
    chk("bp_head_a", ID_EX_Instr, INS_A);
    cyc(1, INS_C, 64'hC, 64'hC0, 0, 0);
    chk("bp_held_ready", id_ready, 1'b0);
    chk("bp_held_head", ID_EX_Instr, INS_A);
    cyc(1, INS_C, 64'hC, 64'hC0, 1, 0);
    chk("bp_head_b", ID_EX_Instr, INS_B);
    chk("bp_ready_again", id_ready, 1'b1);
    cyc(1, INS_C, 64'hC, 64'hC0, 1, 0);
    chk("bp_head_c", ID_EX_Instr, INS_C);
    chk("bp_rA_c", ID_EX_rA, 64'hC);
    cyc(0, 32'd0, 64'h0, 64'h0, 1, 0);
    chk("bp_empty", ID_EX_valid, 1'b0);

    // Flush with buffer full and an incoming instruction
    cyc(1, INS_A, 64'hA, 64'hA0, 0, 0);
    cyc(1, INS_B, 64'hB, 64'hB0, 0, 0);
    cyc(1, INS_C, 64'hC, 64'hC0, 0, 1);
    chk("flush_valid", ID_EX_valid, 1'b0);
    chk("flush_ready", id_ready, 1'b1);
    cyc(0, 32'd0, 64'h0, 64'h0, 0, 0);
    chk("flush_dropped", ID_EX_valid, 1'b0);

    // Asynchronous reset between edges with two entries held
    cyc(1, INS_A, 64'hA, 64'hA0, 0, 0);
    cyc(1, INS_B, 64'hB, 64'hB0, 0, 0);
    if_id_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_vals("arst");
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(1, VAND, 64'h11, 64'h22, 0, 0);
    chk("post_rst_valid", ID_EX_valid, 1'b1);
    chk("post_rst_instr", ID_EX_Instr, VAND);
    cyc(0, 32'd0, 64'h0, 64'h0, 1, 0);

    // Mixed traffic against the model
    for (int i = 0; i < 80; i++) begin
      cyc(1'($urandom_range(0, 1)), tbl[$urandom_range(0, 4)], {32'd0, $urandom},
          {32'd0, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
    cyc(0, 32'd0, 64'h0, 64'h0, 1, 0);
    cyc(0, 32'd0, 64'h0, 64'h0, 1, 0);
    chk("final_empty", ID_EX_valid, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
